// File: rtl/ide_pkg.sv
// Shared types and constants for the IDE sector-buffer burst controller.
package ide_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t PRIME = 2'd1;
    localparam state_t XFER  = 2'd2;

    localparam logic DIR_TO_HOST   = 1'b0;
    localparam logic DIR_FROM_HOST = 1'b1;

    localparam int BUF_WORDS = 512;
endpackage

// File: rtl/ide_buffer_ctrl_if.sv
// Buffer RAM port bundle: one read address and one byte-enabled write port.
interface ide_buffer_ctrl_if #(parameter int ADDR_W = 9);
    logic [ADDR_W-1:0] buf_read_addr;
    logic [ADDR_W-1:0] buf_write_addr;
    logic [15:0]       buf_write_data;
    logic              buf_write_hi;
    logic              buf_write_lo;

    modport master (output buf_read_addr, buf_write_addr, buf_write_data, buf_write_hi, buf_write_lo);
    modport slave  (input  buf_read_addr, buf_write_addr, buf_write_data, buf_write_hi, buf_write_lo);
endinterface

// File: rtl/ide_buffer_port_mux.sv
// Steers the buffer read/write ports between the CPU and the active transfer.
module ide_buffer_port_mux
    import ide_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              busy,
    input  logic              dir,
    input  logic [ADDR_W-1:0] ptr,
    input  logic [ADDR_W-1:0] cpu_buf_addr,
    input  logic [15:0]       cpu_buf_wdata,
    input  logic              cpu_buf_we_hi,
    input  logic              cpu_buf_we_lo,
    input  logic              host_write,
    input  logic [15:0]       ide_wdata,
    ide_buffer_ctrl_if.master bus,
    output logic              cpu_conflict
);
    // ptr is held at zero through PRIME, so the read side needs no PRIME case.
    always_comb begin
        bus.buf_read_addr  = busy ? ptr : cpu_buf_addr;
        bus.buf_write_addr = cpu_buf_addr;
        bus.buf_write_data = cpu_buf_wdata;
        bus.buf_write_hi   = cpu_buf_we_hi;
        bus.buf_write_lo   = cpu_buf_we_lo;
        if (busy) begin
            bus.buf_write_addr = ptr;
            bus.buf_write_data = ide_wdata;
            bus.buf_write_hi   = (dir == DIR_FROM_HOST) && host_write;
            bus.buf_write_lo   = (dir == DIR_FROM_HOST) && host_write;
        end
        cpu_conflict = busy && (cpu_buf_we_hi || cpu_buf_we_lo);
    end
endmodule

// File: rtl/ide_buffer_ctrl.sv
// PIO data-phase sequencer: owns the FSM, word pointer and count for one burst.
module ide_buffer_ctrl
    import ide_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_start,
    input  logic              cpu_dir,
    input  logic [LEN_W-1:0]  cpu_len,
    input  logic              cpu_abort,
    input  logic [ADDR_W-1:0] cpu_buf_addr,
    input  logic [15:0]       cpu_buf_wdata,
    input  logic              cpu_buf_we_hi,
    input  logic              cpu_buf_we_lo,
    input  logic              ide_rd_stb,
    input  logic              ide_wr_stb,
    input  logic [15:0]       ide_wdata,
    ide_buffer_ctrl_if.master bus,
    output logic              busy,
    output logic              drq,
    output logic [LEN_W-1:0]  xfer_count,
    output logic              done,
    output logic              aborted,
    output logic              cpu_conflict
);
    state_t            state;
    logic              dir;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] ptr;
    logic              rd_hit, wr_hit, stb_hit, last_word;

    assign busy      = (state != IDLE);
    assign drq       = (state == XFER);
    assign rd_hit    = drq && (dir == DIR_TO_HOST)   && ide_rd_stb;
    assign wr_hit    = drq && (dir == DIR_FROM_HOST) && ide_wr_stb;
    assign stb_hit   = rd_hit || wr_hit;
    assign last_word = (xfer_count + LEN_W'(1)) == len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            dir        <= DIR_TO_HOST;
            len        <= '0;
            ptr        <= '0;
            xfer_count <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: if (cpu_start && !cpu_abort) begin
                    dir        <= cpu_dir;
                    len        <= (cpu_len == '0) ? LEN_W'(BUF_WORDS) : cpu_len;
                    ptr        <= '0;
                    xfer_count <= '0;
                    state      <= (cpu_dir == DIR_FROM_HOST) ? XFER : PRIME;
                end
                PRIME: begin
                    state <= cpu_abort ? IDLE : XFER;
                    if (cpu_abort) aborted <= 1'b1;
                end
                XFER: begin
                    // A strobe coinciding with abort is still counted.
                    if (stb_hit) begin
                        ptr        <= ptr + ADDR_W'(1);
                        xfer_count <= xfer_count + LEN_W'(1);
                    end
                    if (cpu_abort) begin
                        state   <= IDLE;
                        aborted <= 1'b1;
                    end else if (stb_hit && last_word) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ide_buffer_port_mux #(.ADDR_W(ADDR_W)) u_mux (
        .busy          (busy),
        .dir           (dir),
        .ptr           (ptr),
        .cpu_buf_addr  (cpu_buf_addr),
        .cpu_buf_wdata (cpu_buf_wdata),
        .cpu_buf_we_hi (cpu_buf_we_hi),
        .cpu_buf_we_lo (cpu_buf_we_lo),
        .host_write    (wr_hit),
        .ide_wdata     (ide_wdata),
        .bus           (bus),
        .cpu_conflict  (cpu_conflict)
    );
endmodule

// File: tb/tb_ide_buffer_ctrl.sv
// Scoreboarded random/directed bench for ide_buffer_ctrl with a behavioural buffer RAM.
module tb_ide_buffer_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_start = 0, cpu_dir = 0, cpu_abort = 0;
    logic [9:0]  cpu_len = '0;
    logic [8:0]  cpu_buf_addr = '0;
    logic [15:0] cpu_buf_wdata = '0;
    logic        cpu_buf_we_hi = 0, cpu_buf_we_lo = 0;
    logic        ide_rd_stb = 0, ide_wr_stb = 0;
    logic [15:0] ide_wdata = '0;
    logic        busy, drq, done, aborted, cpu_conflict;
    logic [9:0]  xfer_count;
    logic        host_sample = 0;

    ide_buffer_ctrl_if #(.ADDR_W(9)) bif ();

    ide_buffer_ctrl #(.ADDR_W(9), .LEN_W(10)) dut (
        .clk(clk), .rst(rst), .cpu_start(cpu_start), .cpu_dir(cpu_dir), .cpu_len(cpu_len),
        .cpu_abort(cpu_abort), .cpu_buf_addr(cpu_buf_addr), .cpu_buf_wdata(cpu_buf_wdata),
        .cpu_buf_we_hi(cpu_buf_we_hi), .cpu_buf_we_lo(cpu_buf_we_lo), .ide_rd_stb(ide_rd_stb),
        .ide_wr_stb(ide_wr_stb), .ide_wdata(ide_wdata), .bus(bif), .busy(busy), .drq(drq),
        .xfer_count(xfer_count), .done(done), .aborted(aborted), .cpu_conflict(cpu_conflict)
    );

    always #5 clk = ~clk;

    // Buffer RAM with a one-cycle registered read.
    logic [15:0] mem [512];
    logic [15:0] rd_q;
    always @(posedge clk) begin
        if (bif.buf_write_hi) mem[bif.buf_write_addr][15:8] <= bif.buf_write_data[15:8];
        if (bif.buf_write_lo) mem[bif.buf_write_addr][7:0]  <= bif.buf_write_data[7:0];
        rd_q <= mem[bif.buf_read_addr];
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] ref_mem [512];
    logic [15:0] exp_rd [$];
    int          exp_done [$];
    int          exp_abort [$];
    int          exp_conflict [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        if (host_sample) begin
            if (exp_rd.size() == 0) check("host_rd_unexpected", 1, 0);
            else check("host_rd_data", rd_q, exp_rd.pop_front());
        end
        if (done) begin
            if (exp_done.size() == 0) check("done_unexpected", 1, 0);
            else check("done_count", xfer_count, exp_done.pop_front());
        end
        if (aborted) begin
            if (exp_abort.size() == 0) check("abort_unexpected", 1, 0);
            else check("abort_count", xfer_count, exp_abort.pop_front());
        end
        if (cpu_conflict) begin
            if (exp_conflict.size() == 0) check("conflict_unexpected", 1, 0);
            else check("conflict", 1, exp_conflict.pop_front());
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(int addr, logic [15:0] d, logic hi, logic lo, logic dropped);
        cpu_buf_addr = addr[8:0]; cpu_buf_wdata = d; cpu_buf_we_hi = hi; cpu_buf_we_lo = lo;
        if (dropped) exp_conflict.push_back(1);
        else begin
            if (hi) ref_mem[addr][15:8] = d[15:8];
            if (lo) ref_mem[addr][7:0]  = d[7:0];
        end
        tick();
        cpu_buf_we_hi = 0; cpu_buf_we_lo = 0;
    endtask

    task automatic cpu_read_check(string name, int addr);
        cpu_buf_addr = addr[8:0];
        tick();
        check(name, rd_q, ref_mem[addr]);
    endtask

    task automatic start(logic d, int len, logic ab);
        cpu_dir = d; cpu_len = len[9:0]; cpu_start = 1; cpu_abort = ab;
        tick();
        cpu_start = 0; cpu_abort = 0;
        tick();
    endtask

    task automatic host_read(int gap);
        ide_rd_stb = 1; host_sample = 1;
        tick();
        ide_rd_stb = 0; host_sample = 0;
        tick(gap - 1);
    endtask

    task automatic host_write(logic [15:0] d, int gap, logic ab);
        ide_wdata = d; ide_wr_stb = 1; cpu_abort = ab;
        tick();
        ide_wr_stb = 0; cpu_abort = 0;
        tick(gap - 1);
    endtask

    task automatic do_abort();
        cpu_abort = 1;
        tick();
        cpu_abort = 0;
        tick();
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_drq", drq, 0);
        check("rst_count", xfer_count, 0);
        check("rst_pulses", {done, aborted, cpu_conflict}, 0);
        check("rst_we", {bif.buf_write_hi, bif.buf_write_lo}, 0);
        check("rst_raddr", bif.buf_read_addr, 0);
        rst = 1;
        tick();

        // dir=0 len=4 read burst
        cpu_write(0, 16'h1111, 1, 1, 0);
        cpu_write(1, 16'h2222, 1, 1, 0);
        cpu_write(2, 16'h3333, 1, 1, 0);
        cpu_write(3, 16'h4444, 1, 1, 0);
        start(0, 4, 0);
        check("t1_drq", drq, 1);
        for (int i = 0; i < 4; i++) begin
            exp_rd.push_back(ref_mem[i]);
            if (i == 3) exp_done.push_back(4);
            host_read(3);
        end
        check("t1_count", xfer_count, 4);
        check("t1_drq_low", drq, 0);

        // dir=1 len=0 (512 words)
        start(1, 0, 0);
        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = i[15:0];
            if (i == 511) exp_done.push_back(512);
            host_write(i[15:0], 2, 0);
        end
        check("t2_count", xfer_count, 512);
        ide_wdata = 16'hDEAD; ide_wr_stb = 1;   // stray strobe in IDLE
        tick();
        ide_wr_stb = 0;
        cpu_read_check("t2_addr511", 511);
        cpu_read_check("t2_addr0", 0);

        // dir=1 len=8 abort after 3 strobes
        start(1, 8, 0);
        for (int i = 0; i < 3; i++) begin
            logic [15:0] d = 16'($urandom);
            ref_mem[i] = d;
            host_write(d, 2, 0);
        end
        exp_abort.push_back(3);
        do_abort();
        check("t3_count", xfer_count, 3);
        check("t3_drq", drq, 0);
        host_write(16'hDEAD, 2, 0);
        cpu_read_check("t3_addr3", 3);
        cpu_read_check("t3_addr2", 2);

        // start and abort in the same cycle
        start(0, 4, 1);
        check("t4_busy", busy, 0);

        // abort coincident with the final strobe
        start(1, 2, 0);
        ref_mem[0] = 16'hA5A5; host_write(16'hA5A5, 2, 0);
        ref_mem[1] = 16'h5A5A; exp_abort.push_back(2);
        host_write(16'h5A5A, 2, 1);
        check("t5_busy", busy, 0);
        cpu_read_check("t5_addr1", 1);

        // CPU write conflict during a dir=1 transfer, then byte write in IDLE
        start(1, 4, 0);
        cpu_write(5, 16'hBEEF, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] d = 16'($urandom);
            ref_mem[i] = d;
            if (i == 3) exp_done.push_back(4);
            host_write(d, 2, 0);
        end
        cpu_read_check("t6_addr5_kept", 5);
        cpu_write(5, 16'hBEEF, 1, 0, 0);
        cpu_read_check("t6_addr5_hi", 5);

        // async reset mid dir=0 transfer
        start(0, 8, 0);
        for (int i = 0; i < 2; i++) begin
            exp_rd.push_back(ref_mem[i]);
            host_read(2);
        end
        check("t7_pre_count", xfer_count, 2);
        rst = 0;
        #1;
        check("t7_drq", drq, 0);
        check("t7_busy", busy, 0);
        check("t7_count", xfer_count, 0);
        tick();
        rst = 1;
        tick();
        start(0, 3, 0);
        for (int i = 0; i < 3; i++) begin
            exp_rd.push_back(ref_mem[i]);
            if (i == 2) exp_done.push_back(3);
            host_read(2);
        end
        check("t7_restart_count", xfer_count, 3);

        // randomized transfers against the reference model
        for (int t = 0; t < 8; t++) begin
            logic d = 1'($urandom);
            int len = $urandom_range(1, 16);
            int ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
            int gap = $urandom_range(2, 4);
            start(d, len, 0);
            for (int i = 0; i < len; i++) begin
                if (i == ab) begin
                    exp_abort.push_back(i);
                    do_abort();
                    break;
                end
                if (i == len - 1) exp_done.push_back(len);
                if (d == 0) begin
                    exp_rd.push_back(ref_mem[i]);
                    host_read(gap);
                end else begin
                    logic [15:0] w = 16'($urandom);
                    ref_mem[i] = w;
                    host_write(w, gap, 0);
                end
            end
            check("rnd_count", xfer_count, (ab >= 0) ? ab : len);
            check("rnd_idle", busy, 0);
            cpu_read_check("rnd_readback", $urandom_range(0, len - 1));
        end

        tick(2);
        check("leftover_rd", exp_rd.size(), 0);
        check("leftover_done", exp_done.size(), 0);
        check("leftover_abort", exp_abort.size(), 0);
        check("leftover_conflict", exp_conflict.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
